// File: rtl/aes_pkg.sv
// Shared GF(2^8) constants and the iterative multiplier state encoding.
package aes_pkg;

   localparam logic [7:0] GF_POLY_AES = 8'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } gf_state_t;

endpackage

// File: rtl/gf_xtime.sv
// Multiply-by-x in GF(2^8): shift left, fold the carried-out x^8 back in via POLY.
module gf_xtime #(
   parameter logic [7:0] POLY = 8'h1B
) (
   input  logic [7:0] v,
   output logic [7:0] y
);

   always_comb begin
      y = {v[6:0], 1'b0} ^ (v[7] ? POLY : 8'h00);
   end

endmodule

// File: rtl/gf_mult_iter.sv
// Bit-serial GF(2^8) multiplier: LANES byte products computed MSB-first over 8 cycles.
module gf_mult_iter
   import aes_pkg::*;
#(
   parameter int         LANES = 4,
   parameter logic [7:0] POLY  = GF_POLY_AES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] in_a,
   input  logic [8*LANES-1:0] in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_p
);

   gf_state_t  state, state_nxt;
   logic [2:0] cnt;
   logic       accept;

   logic [7:0] a_q    [LANES];
   logic [7:0] b_q    [LANES];
   logic [7:0] acc    [LANES];
   logic [7:0] acc_xt [LANES];

   assign accept = (state == IDLE) && in_valid;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt <= 3'd0;
         end else if (state == BUSY) begin
            cnt <= cnt + 3'd1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)     state_nxt = BUSY;
         BUSY:    if (cnt == 3'd7)  state_nxt = DONE;
         DONE:    if (out_ready)    state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      gf_xtime #(
         .POLY (POLY)
      ) u_xtime (
         .v (acc[g]),
         .y (acc_xt[g])
      );
   end

   // Horner step: acc = acc*x + b[7-cnt]*a; the accumulator doubles as the result register in DONE.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (!rst) begin
            acc[i] <= 8'h00;
         end else if (accept) begin
            a_q[i] <= in_a[8*i +: 8];
            b_q[i] <= in_b[8*i +: 8];
            acc[i] <= 8'h00;
         end else if (state == BUSY) begin
            acc[i] <= acc_xt[i] ^ (b_q[i][3'd7 - cnt] ? a_q[i] : 8'h00);
         end
      end
   end

   always_comb begin
      out_p = '0;
      for (int i = 0; i < LANES; i++) begin
         out_p[8*i +: 8] = acc[i];
      end
   end

endmodule

// File: tb/tb_gf_mult_iter.sv
// Directed and randomised checks of gf_mult_iter against an LSB-first GF(2^8) model.
module tb_gf_mult_iter;

   localparam int LANES = 4;
   localparam int W     = 8 * LANES;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_p;

   int n_chk  = 0;
   int n_fail = 0;

   gf_mult_iter #(
      .LANES (LANES),
      .POLY  (8'h1B)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Shift-and-add from the LSB of b, reducing a on each doubling.
   function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      logic       hi;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         hi = aa[7];
         aa = aa << 1;
         if (hi) aa = aa ^ 8'h1B;
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [W-1:0] gf_mul_lanes(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r = '0;
      for (int i = 0; i < LANES; i++) r[8*i +: 8] = gf_mul8(a[8*i +: 8], b[8*i +: 8]);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                          input bit scramble, input bit hold_valid, output logic [W-1:0] p);
      int lat;
      check("idle_ready", {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (scramble) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = $urandom;
            in_b      = $urandom;
            out_ready = 1'($urandom_range(0, 1));
         end
         tick();
         lat++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("latency", lat, 32'd8);
      p = out_p;
      check("product", p, gf_mul_lanes(a, b));
      for (int s = 0; s < stall; s++) begin
         tick();
         check("stall_valid", {31'd0, out_valid}, 32'd1);
         check("stall_p", out_p, p);
         check("stall_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      in_valid  = hold_valid;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("post_valid", {31'd0, out_valid}, 32'd0);
      check("post_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [W-1:0] p;
      logic         seen;

      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_a      = '0;
      in_b      = '0;
      tick();
      tick();
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_p", out_p, 32'h0);

      // First cycle with rst high accepts immediately.
      rst = 1'b1;
      run_txn(32'h0000_0057, 32'h0000_0083, 0, 1'b0, 1'b0, p);
      check("fips_57x83", p, 32'h0000_00C1);

      run_txn(32'h0080_5757, 32'hFF02_0213, 0, 1'b0, 1'b0, p);
      check("four_lanes", p, 32'h001B_AEFE);

      run_txn(32'hDEAD_BEEF, 32'h0101_0101, 0, 1'b0, 1'b0, p);
      check("b_one", p, 32'hDEAD_BEEF);

      run_txn(32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, p);
      check("a_zero", p, 32'h0);

      // Backpressure, then a transfer edge with in_valid high must not start a new job.
      run_txn(32'h0A0B_0C0D, 32'hF1E2_D3C4, 5, 1'b0, 1'b1, p);
      check("stall_prod", p, gf_mul_lanes(32'h0A0B_0C0D, 32'hF1E2_D3C4));

      // Inputs churn during BUSY/DONE; only the captured operands matter.
      run_txn(32'h1357_9BDF, 32'h2468_ACE0, 2, 1'b1, 1'b0, p);
      check("scramble_prod", p, gf_mul_lanes(32'h1357_9BDF, 32'h2468_ACE0));
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("no_second_txn", {31'd0, seen}, 32'd0);

      // Abort mid-BUSY at cnt=4.
      in_valid = 1'b1;
      in_a     = 32'h5757_5757;
      in_b     = 32'h8383_8383;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("abort_ready", {31'd0, in_ready}, 32'd1);
      check("abort_valid", {31'd0, out_valid}, 32'd0);
      check("abort_p", out_p, 32'h0);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_valid", {31'd0, seen}, 32'd0);
      run_txn(32'h0280_1B57, 32'h0302_0483, 1, 1'b0, 1'b0, p);

      for (int t = 0; t < 1000; t++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = $urandom;
         rb = $urandom;
         run_txn(ra, rb, $urandom_range(0, 2), 1'b1, 1'b0, p);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
